// File: rtl/sd_iosync_p2ph.sv
// Receive end of a two-phase req/ack crossing. It synchronises s_req, captures
// s_data and holds the word on an srdy/drdy producer interface.
//
// state | meaning
// IDLE  | no word held; waiting for a new s_req toggle
// FULL  | word held on p_data, p_srdy=1; waiting for p_drdy
module sd_iosync_p2ph #(
  parameter int width       = 16,
  parameter int sync_stages = 2,
  parameter int cnt_width   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_req,
  input  logic [width-1:0]     s_data,
  output logic                 s_ack,
  output logic                 p_srdy,
  output logic [width-1:0]     p_data,
  input  logic                 p_drdy,
  output logic                 proto_err,
  output logic [cnt_width-1:0] xfer_cnt
);

  typedef enum logic {IDLE = 1'b0, FULL = 1'b1} state_t;

  localparam logic [cnt_width-1:0] cnt_one = {{(cnt_width-1){1'b0}}, 1'b1};

  state_t                 state, state_nxt;
  logic [sync_stages-1:0] sync_q;
  logic                   req_s;
  logic                   req_last;
  logic                   req_new;
  logic                   capture;
  logic                   accept;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[sync_stages-2:0], s_req};
  end

  assign req_s   = sync_q[sync_stages-1];
  assign req_new = req_s ^ req_last;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (req_new) begin
          capture   = 1'b1;
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (p_drdy) begin
          accept    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    p_srdy = (state == FULL);
  end

  // A toggle seen while FULL leaves req_last alone, so it is captured after the held word leaves.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_last  <= 1'b0;
      p_data    <= '0;
      s_ack     <= 1'b0;
      xfer_cnt  <= '0;
      proto_err <= 1'b0;
    end else begin
      if (capture) begin
        p_data   <= s_data;
        req_last <= req_s;
      end
      if (accept) begin
        s_ack    <= ~s_ack;
        xfer_cnt <= xfer_cnt + cnt_one;
      end
      if ((state == FULL) && req_new) proto_err <= 1'b1;
    end
  end

endmodule
